// File: rtl/ws2812_rx_decoder_if.sv
// LED serial line in, recovered frame/latch/error strobes and forwarded stream out.
// Master side is the decoder; slave side drives din and consumes the results.
// No handshake: every strobe is a single-cycle pulse with no backpressure.
interface ws2812_rx_decoder_if;
  logic        din;
  logic [23:0] frame_data;
  logic        frame_valid;
  logic        latch;
  logic        frame_error;
  logic        dout;

  modport master (
    input  din,
    output frame_data, frame_valid, latch, frame_error, dout
  );

  modport slave (
    output din,
    input  frame_data, frame_valid, latch, frame_error, dout
  );
endinterface

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: pulse-width bit decode, 24-bit GRB frames, reset-gap latch; WS2812_RX_PASSTHROUGH_EN forwards surplus bits.
// Latency: frame_valid 3 clk after the 24th falling edge, latch RESET_CYC+2 clk after the last falling edge.
// No backpressure: outputs are single-cycle strobes; frame_data holds until the next complete frame.
module ws2812_rx_decoder #(
  parameter int THRESH_CYC   = 30,
  parameter int MIN_HIGH_CYC = 5,
  parameter int MAX_HIGH_CYC = 100,
  parameter int RESET_CYC    = 250,
  parameter int CNT_W        = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ws2812_rx_decoder_if.master  bus
);

  localparam logic [CNT_W-1:0] THRESH_V   = CNT_W'(THRESH_CYC);
  localparam logic [CNT_W-1:0] MIN_V      = CNT_W'(MIN_HIGH_CYC);
  localparam logic [CNT_W-1:0] MAX_V      = CNT_W'(MAX_HIGH_CYC);
  localparam logic [CNT_W-1:0] MAX_M1_V   = CNT_W'(MAX_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_V    = CNT_W'(RESET_CYC);
  localparam logic [CNT_W-1:0] RESET_M1_V = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] ONE_V      = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_ERR} state_t;

  state_t             state;
  logic               din_m, din_s, din_d;
  logic               rise, fall;
  logic [CNT_W-1:0]   low_cnt, high_cnt;
  logic [4:0]         bit_cnt;
  logic [23:0]        shreg, next_shreg;
  logic               captured;
  logic [23:0]        frame_data_q;
  logic               frame_valid_q, latch_q, frame_error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_m <= 1'b0;
      din_s <= 1'b0;
      din_d <= 1'b0;
    end else begin
      din_m <= bus.din;
      din_s <= din_m;
      din_d <= din_s;
    end
  end

  assign rise       = din_s & ~din_d;
  assign fall       = ~din_s & din_d;
  assign next_shreg = {shreg[22:0], (high_cnt >= THRESH_V)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      low_cnt       <= '0;
      high_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      captured      <= 1'b0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      latch_q       <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      latch_q       <= 1'b0;
      frame_error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // The power-up gap only arms the receiver; it is not a latch.
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == RESET_M1_V) begin
            low_cnt <= RESET_V;
            bit_cnt <= '0;
            state   <= S_LOW;
          end else begin
            low_cnt <= low_cnt + ONE_V;
          end
        end
        S_LOW: begin
          if (rise) begin
            high_cnt <= ONE_V;
            state    <= S_HIGH;
          end else if (low_cnt == RESET_M1_V) begin
            low_cnt       <= RESET_V;
            latch_q       <= 1'b1;
            frame_error_q <= (bit_cnt != 5'd0) && (bit_cnt < 5'd24);
            bit_cnt       <= '0;
            captured      <= 1'b0;
          end else if (low_cnt != RESET_V) begin
            low_cnt <= low_cnt + ONE_V;
          end
        end
        S_HIGH: begin
          // low_cnt is frozen here so a rejected glitch resumes the running gap.
          if (fall) begin
            state <= S_LOW;
            if (high_cnt >= MIN_V) begin
              low_cnt <= ONE_V;
              if (!captured) begin
                shreg   <= next_shreg;
                bit_cnt <= bit_cnt + 5'd1;
                if (bit_cnt == 5'd23) begin
                  frame_data_q  <= next_shreg;
                  frame_valid_q <= 1'b1;
                  captured      <= 1'b1;
                end
              end
            end
          end else if (high_cnt == MAX_M1_V) begin
            high_cnt      <= MAX_V;
            low_cnt       <= '0;
            frame_error_q <= 1'b1;
            state         <= S_ERR;
          end else begin
            high_cnt <= high_cnt + ONE_V;
          end
        end
        S_ERR: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == RESET_M1_V) begin
            low_cnt  <= RESET_V;
            latch_q  <= 1'b1;
            bit_cnt  <= '0;
            captured <= 1'b0;
            state    <= S_LOW;
          end else begin
            low_cnt <= low_cnt + ONE_V;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.latch       = latch_q;
  assign bus.frame_error = frame_error_q;

`ifdef WS2812_RX_PASSTHROUGH_EN
  assign bus.dout = din_s & captured;
`else
  assign bus.dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx_decoder.sv
// Randomized bench for ws2812_rx_decoder: a pulse-level model predicts every strobe by cycle.
// Latency: expectations are keyed on the clock cycle the strobe must appear in.
// No backpressure: the bench drives din with fixed durations and monitors every cycle.
module tb_ws2812_rx_decoder;

  localparam int THRESH = 30;
  localparam int MINH   = 5;
  localparam int MAXH   = 100;
  localparam int RST    = 250;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  ws2812_rx_decoder_if bus ();

  ws2812_rx_decoder #(
    .THRESH_CYC   (THRESH),
    .MIN_HIGH_CYC (MINH),
    .MAX_HIGH_CYC (MAXH),
    .RESET_CYC    (RST),
    .CNT_W        (12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: expected strobes keyed by the cycle they must appear in.
  logic [23:0] exp_fv   [int];
  bit          exp_latch[int];
  bit          exp_err  [int];
  int          cap_evt  [int];
  bit          dhist    [int];
  logic [23:0] acc;
  logic [23:0] frame_hold;
  int          nbits;
  bit          captured;
  bit          err_mode;
  bit          cap_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_fv.delete();
    exp_latch.delete();
    exp_err.delete();
    cap_evt.delete();
    acc        = '0;
    frame_hold = '0;
    nbits      = 0;
    captured   = 1'b0;
    err_mode   = 1'b0;
    cap_model  = 1'b0;
  endtask

  // One high pulse of h cycles followed by l low cycles, with its predicted effect.
  task automatic pulse(input int h, input int l);
    int cr, cf;
    cr = cyc;
    cf = cr + h;
    if (h >= MAXH) begin
      if (!err_mode) exp_err[cr + 2 + MAXH] = 1'b1;
      err_mode = 1'b1;
    end else if (h >= MINH && !err_mode && !captured) begin
      acc = {acc[22:0], (h >= THRESH)};
      nbits++;
      if (nbits == 24) begin
        exp_fv[cf + 3]  = acc;
        cap_evt[cf + 3] = 1;
        captured        = 1'b1;
        frame_hold      = acc;
      end
    end
    if (l >= RST) begin
      exp_latch[cf + RST + 2] = 1'b1;
      if (!err_mode && nbits > 0 && nbits < 24) exp_err[cf + RST + 2] = 1'b1;
      if (captured) cap_evt[cf + RST + 2] = 0;
      nbits    = 0;
      captured = 1'b0;
      err_mode = 1'b0;
    end
    bus.din = 1'b1;
    repeat (h) @(posedge clk);
    #1;
    bus.din = 1'b0;
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic bit_widths(input logic b, input bit fixed, output int h, output int l);
    if (fixed) begin
      h = b ? 40 : 20;
      l = b ? 22 : 42;
    end else if (b) begin
      h = $urandom_range(60, THRESH);
      l = $urandom_range(30, 8);
    end else begin
      h = $urandom_range(THRESH - 2, MINH);
      l = $urandom_range(50, 10);
    end
  endtask

  // Sends d[n-1:0] MSB first; the final bit's low phase lasts last_low cycles.
  task automatic send_bits(input logic [23:0] d, input int n, input int last_low, input bit fixed);
    int h, l;
    for (int i = n - 1; i >= 0; i--) begin
      bit_widths(d[i], fixed, h, l);
      if (i == 0) l = last_low;
      pulse(h, l);
    end
  endtask

  task automatic idle_low(input int n);
    bus.din = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_data"},  bus.frame_data,  32'h0);
    check_eq({tag, "_fv"},    bus.frame_valid, 32'h0);
    check_eq({tag, "_latch"}, bus.latch,       32'h0);
    check_eq({tag, "_err"},   bus.frame_error, 32'h0);
    check_eq({tag, "_dout"},  bus.dout,        32'h0);
  endtask

  // Per-cycle monitor: any strobe that fires, or is expected, is compared.
  always @(negedge clk) begin
    logic e_d;
    dhist[cyc] = bus.din;
    if (rst_n) begin
      if (cap_evt.exists(cyc)) begin
        cap_model = (cap_evt[cyc] != 0);
        cap_evt.delete(cyc);
      end
      if (bus.frame_valid || exp_fv.exists(cyc)) begin
        check_eq("frame_valid", bus.frame_valid, exp_fv.exists(cyc));
        if (exp_fv.exists(cyc)) begin
          check_eq("frame_data", bus.frame_data, exp_fv[cyc]);
          exp_fv.delete(cyc);
        end
      end
      if (bus.latch || exp_latch.exists(cyc)) begin
        check_eq("latch", bus.latch, exp_latch.exists(cyc));
        exp_latch.delete(cyc);
      end
      if (bus.frame_error || exp_err.exists(cyc)) begin
        check_eq("frame_error", bus.frame_error, exp_err.exists(cyc));
        exp_err.delete(cyc);
      end
`ifdef WS2812_RX_PASSTHROUGH_EN
      e_d = cap_model && dhist.exists(cyc - 2) && dhist[cyc - 2];
`else
      e_d = 1'b0;
`endif
      if (bus.dout || e_d) check_eq("dout", bus.dout, e_d);
    end
  end

  initial begin
    int h, l;
    logic [23:0] d;
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    rst_n   = 1'b0;
    bus.din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_low(RST + 10);

    // Reference frame with nominal widths, then a clean gap.
    send_bits(24'hA5C3F0, 24, RST, 1'b1);
    check_eq("hold_a5c3f0", bus.frame_data, 32'hA5C3F0);

    // Truncated frame: latch and frame_error together, data held.
    send_bits(24'($urandom), 10, RST + 5, 1'b0);
    check_eq("hold_partial", bus.frame_data, frame_hold);

    // Glitch in the low phase of bit 5 of 0x00FF00.
    d = 24'h00FF00;
    for (int i = 23; i >= 0; i--) begin
      bit_widths(d[i], 1'b0, h, l);
      if (i == 0) l = RST;
      pulse(h, l);
      if (i == 18) pulse(MINH - 2, 20);
    end
    check_eq("hold_glitch", bus.frame_data, 32'h00FF00);

    // Back-to-back frames: only the first is decoded.
    send_bits(24'h123456, 24, 20, 1'b0);
    send_bits(24'hFEDCBA, 24, RST, 1'b0);
    check_eq("hold_b2b", bus.frame_data, 32'h123456);

    // A low of RST-1 is not a gap, so the next 24 bits are still surplus.
    d = 24'($urandom);
    send_bits(d, 24, RST - 1, 1'b0);
    send_bits(24'($urandom), 24, RST + 3, 1'b0);
    check_eq("hold_short_gap", bus.frame_data, d);

    // Width boundaries: MIN and THRESH-1 decode 0, THRESH and MAX-1 decode 1, MIN-1 is a glitch.
    pulse(MINH, 20);
    pulse(MINH - 1, 20);
    pulse(THRESH - 1, 20);
    pulse(THRESH, 20);
    pulse(MAXH - 1, 20);
    send_bits(24'($urandom), 20, RST, 1'b0);
    check_eq("hold_bounds", bus.frame_data, frame_hold);

    // Over-long high: frame_error, then recovery through a gap.
    pulse(120, RST);
    send_bits(24'h0F0F0F, 24, RST, 1'b0);
    check_eq("hold_recover", bus.frame_data, 32'h0F0F0F);

    // Random frames with random gap lengths.
    for (int k = 0; k < 4; k++) begin
      d = 24'($urandom);
      send_bits(d, 24, $urandom_range(RST + 20, RST), 1'b0);
      check_eq("hold_rand", bus.frame_data, d);
    end

    // Reset mid-frame: outputs clear at once, next frame decodes.
    send_bits(24'($urandom), 12, 20, 1'b0);
    bus.din = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    bus.din = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle_low(RST + 10);
    d = 24'($urandom);
    send_bits(d, 24, RST + 5, 1'b0);
    check_eq("hold_after_reset", bus.frame_data, d);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
